// File: rtl/reg_serializer_pkg.sv
// ---------------------------------------------------------------------------
// reg_serializer_pkg
// Shared definitions for the register serializer: FSM state encoding and
// frame geometry constants.
// ---------------------------------------------------------------------------
package reg_serializer_pkg;

   // Frame is start bit + DATA_BITS data bits + stop bit.
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SHIFT = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Free-running modulo-DIV cycle counter used to time each serial bit.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears the count
//   clear      holds the count at 0 (used while the serializer is idle)
//   tick       high while the count is DIV-1 (last cycle of a bit)
//   tick_next  high when the count in the next cycle will be DIV-1; lets the
//              parent register outputs that must coincide with tick
// ---------------------------------------------------------------------------
module bit_timer #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic tick_next
);

   localparam logic [7:0] LAST = 8'(DIV - 1);

   logic [7:0] count;
   logic [7:0] count_next;

   // Wraps to 0 after DIV-1, so the count never leaves 0..DIV-1.
   assign tick       = (count == LAST);
   assign count_next = (clear || tick) ? 8'd0 : count + 8'd1;
   assign tick_next  = (count_next == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 8'd0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/reg_serializer.sv
// ---------------------------------------------------------------------------
// reg_serializer
// Transmits an 8-bit word as a 10-bit serial frame: start bit (0), data MSB
// first, stop bit (1). Each bit lasts DIV clock cycles.
//
// Handshake: ena is a request, busy is the inverse of ready. A request is
// accepted at a rising edge where ena=1 and busy=0; data is captured at that
// same edge. Requests while busy=1 (including the done cycle) are dropped,
// nothing is queued.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any frame in flight
//   data[7:0]  parallel word, sampled only on acceptance
//   ena        transmit request
//   busy       high while a frame is in progress
//   ser_out    serial line, idle high
//   ser_frame  high exactly while data bits are on ser_out
//   done       one-cycle pulse in the last cycle of the stop bit
//   dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module reg_serializer
   import reg_serializer_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       ena,
   output logic       busy,
   output logic       ser_out,
   output logic       ser_frame,
   output logic       done,
   output state_t     dbg_state
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   state_t                 state, state_next;
   logic [DATA_BITS-1:0]   sreg, sreg_next;
   logic [BW-1:0]          bitcnt, bitcnt_next;
   logic                   tick, tick_next;
   logic                   timer_clear;

   logic busy_d, ser_out_d, ser_frame_d, done_d;

   // Timer sits at 0 while idle so the start bit gets a full DIV cycles.
   assign timer_clear = (state == IDLE);

   bit_timer #(.DIV(DIV)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (timer_clear),
      .tick      (tick),
      .tick_next (tick_next)
   );

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         bitcnt    <= '0;
         busy      <= 1'b0;
         ser_out   <= 1'b1;
         ser_frame <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         sreg      <= sreg_next;
         bitcnt    <= bitcnt_next;
         busy      <= busy_d;
         ser_out   <= ser_out_d;
         ser_frame <= ser_frame_d;
         done      <= done_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_next  = state;
      sreg_next   = sreg;
      bitcnt_next = bitcnt;
      case (state)
         IDLE: begin
            if (ena) begin
               state_next = START;
               sreg_next  = data;
            end
         end
         START: begin
            if (tick) state_next = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               // Left shift keeps the bit to transmit in sreg[MSB].
               sreg_next   = {sreg[DATA_BITS-2:0], 1'b0};
               bitcnt_next = bitcnt + 1'b1;
               if (bitcnt == LAST_BIT) state_next = STOP;
            end
         end
         STOP: begin
            if (tick) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode from the upcoming state, so the registered outputs line up
   // with the state they describe.
   always_comb begin
      busy_d      = (state_next != IDLE);
      ser_frame_d = (state_next == SHIFT);
      done_d      = (state_next == STOP) && tick_next;
      case (state_next)
         START:   ser_out_d = 1'b0;
         SHIFT:   ser_out_d = sreg_next[DATA_BITS-1];
         default: ser_out_d = 1'b1;
      endcase
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_reg_serializer.sv
// ---------------------------------------------------------------------------
// tb_reg_serializer
// Directed bench for reg_serializer with three instances (DIV = 4, 1, 3).
// ---------------------------------------------------------------------------
module tb_reg_serializer;
   import reg_serializer_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a   [3];
   logic       ena_a   [3];
   logic [7:0] data_a  [3];
   logic       busy_a  [3];
   logic       ser_a   [3];
   logic       frame_a [3];
   logic       done_a  [3];
   state_t     st_a    [3];

   reg_serializer #(.DIV(4)) u0 (
      .clk(clk), .rst(rst_a[0]), .data(data_a[0]), .ena(ena_a[0]),
      .busy(busy_a[0]), .ser_out(ser_a[0]), .ser_frame(frame_a[0]),
      .done(done_a[0]), .dbg_state(st_a[0]));

   reg_serializer #(.DIV(1)) u1 (
      .clk(clk), .rst(rst_a[1]), .data(data_a[1]), .ena(ena_a[1]),
      .busy(busy_a[1]), .ser_out(ser_a[1]), .ser_frame(frame_a[1]),
      .done(done_a[1]), .dbg_state(st_a[1]));

   reg_serializer #(.DIV(3)) u2 (
      .clk(clk), .rst(rst_a[2]), .data(data_a[2]), .ena(ena_a[2]),
      .busy(busy_a[2]), .ser_out(ser_a[2]), .ser_frame(frame_a[2]),
      .done(done_a[2]), .dbg_state(st_a[2]));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_cycle(input int idx, input int cyc, input logic es,
                              input logic eb, input logic ef, input logic ed);
      check($sformatf("u%0d c%0d ser_out", idx, cyc),   32'(ser_a[idx]),   32'(es));
      check($sformatf("u%0d c%0d busy", idx, cyc),      32'(busy_a[idx]),  32'(eb));
      check($sformatf("u%0d c%0d ser_frame", idx, cyc), 32'(frame_a[idx]), 32'(ef));
      check($sformatf("u%0d c%0d done", idx, cyc),      32'(done_a[idx]),  32'(ed));
   endtask

   // ---------------- driver ----------------
   // One-cycle ena at edge T, then samples cycles T+1 .. T+10*div+2.
   // data is changed to d_after at T+1; ena is re-pulsed in cycles p1/p2.
   task automatic send_frame(input int idx, input int div, input logic [7:0] d,
                             input logic [9:0] bits, input logic [7:0] d_after,
                             input int p1, input int p2);
      int fcnt = 0;
      int dcnt = 0;
      @(negedge clk);
      data_a[idx] = d;
      ena_a[idx]  = 1'b1;
      for (int c = 1; c <= 10 * div + 2; c++) begin
         @(negedge clk);
         if (c == 1) data_a[idx] = d_after;
         ena_a[idx] = (c == p1) || (c == p2);
         if (c <= 10 * div)
            check_cycle(idx, c, bits[9 - (c - 1) / div], 1'b1,
                        (c > div) && (c <= 9 * div), c == 10 * div);
         else
            check_cycle(idx, c, 1'b1, 1'b0, 1'b0, 1'b0);
         if (frame_a[idx]) fcnt++;
         if (done_a[idx])  dcnt++;
      end
      ena_a[idx] = 1'b0;
      check($sformatf("u%0d frame_len", idx), 32'(fcnt), 32'(8 * div));
      check($sformatf("u%0d done_count", idx), 32'(dcnt), 32'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         idx;
      int         div;
      logic [7:0] d;
      logic [9:0] bits;     // expected line, first bit transmitted in [9]
      logic [7:0] d_after;
      int         p1;
      int         p2;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{idx: 0, div: 4, d: 8'hA5, bits: 10'b0101001011, d_after: 8'h5A, p1: 0,  p2: 0};
      vecs[1] = '{idx: 0, div: 4, d: 8'h3C, bits: 10'b0001111001, d_after: 8'hC3, p1: 10, p2: 40};
      vecs[2] = '{idx: 1, div: 1, d: 8'h00, bits: 10'b0000000001, d_after: 8'hFF, p1: 0,  p2: 0};
      vecs[3] = '{idx: 1, div: 1, d: 8'hFF, bits: 10'b0111111111, d_after: 8'h00, p1: 0,  p2: 0};
      vecs[4] = '{idx: 2, div: 3, d: 8'h81, bits: 10'b0100000011, d_after: 8'h00, p1: 0,  p2: 0};
      vecs[5] = '{idx: 2, div: 3, d: 8'h5A, bits: 10'b0010110101, d_after: 8'hFF, p1: 0,  p2: 0};

      for (int i = 0; i < 3; i++) begin
         rst_a[i]  = 1'b1;
         ena_a[i]  = 1'b0;
         data_a[i] = 8'h00;
      end
      repeat (3) @(negedge clk);

      // Reset state on every instance.
      for (int i = 0; i < 3; i++) begin
         check_cycle(i, 0, 1'b1, 1'b0, 1'b0, 1'b0);
         check($sformatf("u%0d reset state", i), 32'(st_a[i]), 32'(IDLE));
         rst_a[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_cycle(i, 0, 1'b1, 1'b0, 1'b0, 1'b0);

      // rst wins over ena in the same cycle.
      rst_a[0] = 1'b1;
      ena_a[0] = 1'b1;
      @(negedge clk);
      check("rst_over_ena busy", 32'(busy_a[0]), 32'd0);
      check("rst_over_ena state", 32'(st_a[0]), 32'(IDLE));
      rst_a[0] = 1'b0;
      ena_a[0] = 1'b0;
      @(negedge clk);
      check("after_rst busy", 32'(busy_a[0]), 32'd0);

      // Table-driven frames.
      for (int v = 0; v < 6; v++)
         send_frame(vecs[v].idx, vecs[v].div, vecs[v].d, vecs[v].bits,
                    vecs[v].d_after, vecs[v].p1, vecs[v].p2);

      // Back-to-back with ena held high on DIV=1: 00 frame, 1 idle cycle, FF frame.
      begin
         logic [9:0] b0;
         logic [9:0] b1;
         b0 = 10'b0000000001;
         b1 = 10'b0111111111;
         @(negedge clk);
         data_a[1] = 8'h00;
         ena_a[1]  = 1'b1;
         for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1)  data_a[1] = 8'hFF;
            if (c == 21) ena_a[1]  = 1'b0;
            if (c <= 10)
               check_cycle(1, 100 + c, b0[10 - c], 1'b1, (c > 1) && (c <= 9), c == 10);
            else if (c >= 12 && c <= 21)
               check_cycle(1, 100 + c, b1[21 - c], 1'b1, (c > 12) && (c <= 20), c == 21);
            else
               check_cycle(1, 100 + c, 1'b1, 1'b0, 1'b0, 1'b0);
         end
      end

      // Reset mid-frame on DIV=4 at T+18.
      begin
         logic [9:0] ba;
         int dcnt = 0;
         int bcnt = 0;
         ba = 10'b0101001011;
         @(negedge clk);
         data_a[0] = 8'hA5;
         ena_a[0]  = 1'b1;
         for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            ena_a[0] = 1'b0;
            check_cycle(0, 200 + c, ba[9 - (c - 1) / 4], 1'b1, c > 4, 1'b0);
         end
         rst_a[0] = 1'b1;
         @(negedge clk);
         rst_a[0] = 1'b0;
         check_cycle(0, 219, 1'b1, 1'b0, 1'b0, 1'b0);
         check("abort state", 32'(st_a[0]), 32'(IDLE));
         for (int c = 20; c <= 60; c++) begin
            @(negedge clk);
            if (done_a[0]) dcnt++;
            if (busy_a[0]) bcnt++;
         end
         check("abort no_done", 32'(dcnt), 32'd0);
         check("abort no_busy", 32'(bcnt), 32'd0);
         send_frame(0, 4, 8'hA5, ba, 8'h00, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
